chi_best_select: RTL and testbench
==================================

Name: chi_best_select

Overview:
- Consumes the registered chi-square stream produced by the chi-square multiplexer stage, one value per fit combination.
- Tracks the minimum chi-square and its fit index across all combinations of one road.
- On end-of-road, latches the winner, its fit count and the pass/fail result against a programmable cut into an output register with valid/ready handshake.
- Feeds the track output formatter.

Parameters:
- PARAMETERBITS, 14, chi-square width; matches the upstream multiplexer output.
- IDBITS, 8, fit combination index width.
- CNTBITS, 8, width of per-road fit counter.
- TIMEOUT, 255, idle cycles before forced road close (only with optional feature).

Ports:
- CLOCK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- CHI  input  PARAMETERBITS  chi-square value from upstream stage.
- CHI_VALID  input  1  CHI/FIT_ID/LAST valid this cycle.
- FIT_ID  input  IDBITS  combination index of CHI.
- LAST  input  1  qualifies the final fit of the current road.
- CHI_CUT  input  PARAMETERBITS  quasi-static acceptance threshold.
- IN_READY  output  1  stage can accept a fit this cycle.
- OUT_VALID  output  1  output register holds a road result.
- OUT_READY  input  1  downstream accepts result.
- BEST_CHI  output  PARAMETERBITS  minimum chi-square of road.
- BEST_ID  output  IDBITS  FIT_ID of the minimum.
- NFITS  output  CNTBITS  fits accepted in road, saturating.
- PASS  output  1  BEST_CHI <= CHI_CUT.
- TIMED_OUT  output  1  road closed by watchdog; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset: all outputs 0 except IN_READY; accumulator cleared; state IDLE. IN_READY is combinational and equals 1 whenever RESET=0 and the output register is free. Reset mid-road discards the partial road and any unread result.
- Accept = CHI_VALID & IN_READY.
- IN_READY = !OUT_VALID | OUT_READY.
- States:
  - IDLE: no fit held. Accept loads acc_chi=CHI, acc_id=FIT_ID, acc_cnt=1, then goes to ACCUM. Accept with LAST closes a single-fit road immediately.
  - ACCUM: on accept, if CHI < acc_chi (unsigned, strict) then acc_chi/acc_id are replaced. On ties the earlier fit wins. acc_cnt increments and saturates at 2^CNTBITS-1.
  - Close: accept with LAST=1, in either state.
    - Next cycle OUT_VALID=1 with BEST_CHI/BEST_ID including the LAST fit; NFITS includes the LAST fit.
    - PASS is computed against CHI_CUT sampled on the closing cycle.
    - State returns to IDLE.
- Latency: LAST accepted at cycle n gives the result visible at n+1.
- Output register holds its contents stable while OUT_VALID & !OUT_READY. OUT_VALID & OUT_READY with no new close clears OUT_VALID next cycle.
- Back-to-back roads: a close in the same cycle as OUT_READY=1 overwrites the register, and OUT_VALID stays 1. A new road may begin the cycle after a close with no bubble.
- CHI_VALID while IN_READY=0 is ignored; upstream must hold the fit.
- LAST without CHI_VALID is ignored.
- CHI=all-ones is a legal value, not a sentinel.

Optional Feature:
- Macro CHI_BEST_TIMEOUT_EN.
- Defined:
  - An idle counter runs in ACCUM, is cleared on every accept, and counts cycles with no accept.
  - When it reaches TIMEOUT, the road is closed as if LAST arrived, without adding a fit. TIMED_OUT=1 accompanies that result.
  - If the output register is occupied, the forced close waits until IN_READY=1.
- Undefined: no counter is built, TIMED_OUT is tied 0, and ACCUM persists until LAST.

Test Plan:
- Reset then road of fits (CHI,ID) = (500,0),(120,1),(300,2,LAST), CHI_CUT=200, OUT_READY=1 -> one cycle after LAST: OUT_VALID=1, BEST_CHI=120, BEST_ID=1, NFITS=3, PASS=1.
- Tie handling: (90,4),(90,7,LAST), CHI_CUT=80 -> BEST_ID=4, BEST_CHI=90, PASS=0.
- Single-fit road (16383,9,LAST) -> BEST_CHI=16383, NFITS=1, PASS=1 with CHI_CUT=16383.
- Backpressure: OUT_READY=0 after a close -> IN_READY=0; new fits are held upstream and result fields stay frozen for 5 cycles. On OUT_READY=1, the next road is accepted the same cycle with no data loss.
- Back-to-back closes with OUT_READY=1 for two LAST-only fits (10,1) and (20,2) on consecutive cycles -> OUT_VALID continuously 1, results 10/1 then 20/2.
- Saturation and reset: 300 fits with CNTBITS=8 -> NFITS=255. Separately, asserting RESET mid-road -> outputs 0; the next road's result excludes pre-reset fits.
- Watchdog (with CHI_BEST_TIMEOUT_EN, TIMEOUT=4): fit (50,3) then no valid for 4 cycles -> forced result BEST_CHI=50, NFITS=1, TIMED_OUT=1.

Source files
------------

// File: rtl/chi_best_select_if.sv
// rtl/chi_best_select_if.sv - fit stream in / road result out bundle for chi_best_select
// Upstream stage and formatter sit on the master side; chi_best_select is the slave.
interface chi_best_select_if #(
   parameter int PARAMETERBITS = 14,
   parameter int IDBITS        = 8,
   parameter int CNTBITS       = 8
);
   logic [PARAMETERBITS-1:0] CHI;
   logic                     CHI_VALID;
   logic [IDBITS-1:0]        FIT_ID;
   logic                     LAST;
   logic [PARAMETERBITS-1:0] CHI_CUT;
   logic                     IN_READY;
   logic                     OUT_VALID;
   logic                     OUT_READY;
   logic [PARAMETERBITS-1:0] BEST_CHI;
   logic [IDBITS-1:0]        BEST_ID;
   logic [CNTBITS-1:0]       NFITS;
   logic                     PASS;
   logic                     TIMED_OUT;

   modport master (
      output CHI, CHI_VALID, FIT_ID, LAST, CHI_CUT, OUT_READY,
      input  IN_READY, OUT_VALID, BEST_CHI, BEST_ID, NFITS, PASS, TIMED_OUT
   );

   modport slave (
      input  CHI, CHI_VALID, FIT_ID, LAST, CHI_CUT, OUT_READY,
      output IN_READY, OUT_VALID, BEST_CHI, BEST_ID, NFITS, PASS, TIMED_OUT
   );
endinterface

// File: rtl/chi_best_select.sv
// rtl/chi_best_select.sv - per-road minimum chi-square selector with registered result
// Optional road watchdog enabled by macro CHI_BEST_TIMEOUT_EN.
module chi_best_select #(
   parameter int PARAMETERBITS = 14,
   parameter int IDBITS        = 8,
   parameter int CNTBITS       = 8,
   parameter int TIMEOUT       = 255
) (
   input logic              CLOCK,
   input logic              RESET,
   chi_best_select_if.slave bus
);
   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                   state_q, state_d;
   logic [PARAMETERBITS-1:0] acc_chi;
   logic [IDBITS-1:0]        acc_id;
   logic [CNTBITS-1:0]       acc_cnt;
   logic [PARAMETERBITS-1:0] merge_chi;
   logic [IDBITS-1:0]        merge_id;
   logic [CNTBITS-1:0]       merge_cnt;
   logic                     out_valid;
   logic [PARAMETERBITS-1:0] best_chi;
   logic [IDBITS-1:0]        best_id;
   logic [CNTBITS-1:0]       nfits;
   logic                     pass;
   logic                     in_ready;
   logic                     accept;
   logic                     close_last;
   logic                     close_forced;

   assign in_ready   = !out_valid || bus.OUT_READY;
   assign accept     = bus.CHI_VALID && in_ready;
   assign close_last = accept && bus.LAST;

`ifdef CHI_BEST_TIMEOUT_EN
   localparam int IDLEBITS = $clog2(TIMEOUT + 1);

   logic [IDLEBITS-1:0] idle_cnt;
   logic                timed_out;

   always_ff @(posedge CLOCK) begin
      if (RESET || state_q != ACCUM || accept)
         idle_cnt <= '0;
      else if (idle_cnt != IDLEBITS'(TIMEOUT))
         idle_cnt <= idle_cnt + IDLEBITS'(1);
   end

   // A due watchdog close waits for the output register to be free.
   assign close_forced = (state_q == ACCUM) && !accept && in_ready &&
                         (idle_cnt == IDLEBITS'(TIMEOUT));
`else
   assign close_forced = 1'b0;
`endif

   // Road state including the fit offered this cycle; ties keep the earlier fit.
   always_comb begin
      merge_chi = bus.CHI;
      merge_id  = bus.FIT_ID;
      merge_cnt = CNTBITS'(1);
      if (state_q == ACCUM) begin
         merge_cnt = (&acc_cnt) ? acc_cnt : acc_cnt + CNTBITS'(1);
         if (!(bus.CHI < acc_chi)) begin
            merge_chi = acc_chi;
            merge_id  = acc_id;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept && !bus.LAST)
               state_d = ACCUM;
         end
         ACCUM: begin
            if (close_last || close_forced)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         acc_chi   <= '0;
         acc_id    <= '0;
         acc_cnt   <= '0;
         out_valid <= 1'b0;
         best_chi  <= '0;
         best_id   <= '0;
         nfits     <= '0;
         pass      <= 1'b0;
`ifdef CHI_BEST_TIMEOUT_EN
         timed_out <= 1'b0;
`endif
      end else begin
         if (accept) begin
            acc_chi <= merge_chi;
            acc_id  <= merge_id;
            acc_cnt <= merge_cnt;
         end
         if (close_last) begin
            out_valid <= 1'b1;
            best_chi  <= merge_chi;
            best_id   <= merge_id;
            nfits     <= merge_cnt;
            pass      <= (merge_chi <= bus.CHI_CUT);
`ifdef CHI_BEST_TIMEOUT_EN
            timed_out <= 1'b0;
`endif
         end else if (close_forced) begin
            out_valid <= 1'b1;
            best_chi  <= acc_chi;
            best_id   <= acc_id;
            nfits     <= acc_cnt;
            pass      <= (acc_chi <= bus.CHI_CUT);
`ifdef CHI_BEST_TIMEOUT_EN
            timed_out <= 1'b1;
`endif
         end else if (bus.OUT_READY) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign bus.IN_READY  = in_ready;
   assign bus.OUT_VALID = out_valid;
   assign bus.BEST_CHI  = best_chi;
   assign bus.BEST_ID   = best_id;
   assign bus.NFITS     = nfits;
   assign bus.PASS      = pass;
`ifdef CHI_BEST_TIMEOUT_EN
   assign bus.TIMED_OUT = timed_out;
`else
   assign bus.TIMED_OUT = 1'b0;
`endif
endmodule

// File: tb/tb_chi_best_select.sv
// tb/tb_chi_best_select.sv - vector table, corner sequences and random scoreboard for chi_best_select
// Watchdog sequence is compiled in with CHI_BEST_TIMEOUT_EN.
module tb_chi_best_select;
   localparam int PB = 14;
   localparam int IB = 8;
   localparam int CB = 8;
   localparam int TO = 4;
   localparam int CHI_MAX = (1 << PB) - 1;
   localparam int CNT_MAX = (1 << CB) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   chi_best_select_if #(.PARAMETERBITS(PB), .IDBITS(IB), .CNTBITS(CB)) bus ();

   chi_best_select #(.PARAMETERBITS(PB), .IDBITS(IB), .CNTBITS(CB), .TIMEOUT(TO)) dut (
      .CLOCK(clk),
      .RESET(rst),
      .bus  (bus)
   );

   typedef struct {
      int n;
      int chi[4];
      int id[4];
      int cut;
      int e_chi;
      int e_id;
      int e_n;
      int e_pass;
   } road_vec_t;

   typedef struct {
      int chi;
      int id;
      int n;
      int pass;
   } result_t;

   int      checks = 0;
   int      errors = 0;
   result_t exp_q[$];
   int      road_chi[$];
   int      road_id[$];
   bit      mon_en = 1'b0;
   bit      rand_ready = 1'b0;
   int      zero_run = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: earliest minimum over the road, count clipped to the counter range.
   function automatic result_t model(input int cut);
      result_t r;
      r.chi = road_chi[0];
      r.id  = road_id[0];
      foreach (road_chi[i])
         if (road_chi[i] < r.chi) begin
            r.chi = road_chi[i];
            r.id  = road_id[i];
         end
      r.n    = (road_chi.size() > CNT_MAX) ? CNT_MAX : road_chi.size();
      r.pass = (r.chi <= cut) ? 1 : 0;
      return r;
   endfunction

   task automatic tick();
      result_t e;
      if (mon_en && bus.OUT_VALID && bus.OUT_READY) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("rand_best_chi", bus.BEST_CHI, e.chi);
            check("rand_best_id", bus.BEST_ID, e.id);
            check("rand_nfits", bus.NFITS, e.n);
            check("rand_pass", bus.PASS, e.pass);
            check("rand_timed_out", bus.TIMED_OUT, 0);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ready();
      if (rand_ready) begin
         if (zero_run >= 2) bus.OUT_READY = 1'b1;
         else bus.OUT_READY = 1'($urandom_range(0, 1));
         zero_run = bus.OUT_READY ? 0 : zero_run + 1;
      end
      #1;
   endtask

   task automatic idle_cycle();
      drive_ready();
      tick();
   endtask

   task automatic send_fit(input int chi, input int id, input bit last);
      bit ok;
      ok = 1'b0;
      bus.CHI       = PB'(chi);
      bus.FIT_ID    = IB'(id);
      bus.LAST      = last;
      bus.CHI_VALID = 1'b1;
      for (int c = 0; c < 1000 && !ok; c++) begin
         drive_ready();
         if (bus.IN_READY) ok = 1'b1;
         tick();
      end
      bus.CHI_VALID = 1'b0;
      bus.LAST      = 1'b0;
      if (!ok) check("send_timeout", 0, 1);
   endtask

   road_vec_t vecs[3];
   result_t   r;
   int        cut;
   int        len;
   int        v_chi;
   bit        found;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0].n = 3; vecs[0].chi = '{500, 120, 300, 0}; vecs[0].id = '{0, 1, 2, 0};
      vecs[0].cut = 200; vecs[0].e_chi = 120; vecs[0].e_id = 1; vecs[0].e_n = 3; vecs[0].e_pass = 1;
      vecs[1].n = 2; vecs[1].chi = '{90, 90, 0, 0}; vecs[1].id = '{4, 7, 0, 0};
      vecs[1].cut = 80; vecs[1].e_chi = 90; vecs[1].e_id = 4; vecs[1].e_n = 2; vecs[1].e_pass = 0;
      vecs[2].n = 1; vecs[2].chi = '{16383, 0, 0, 0}; vecs[2].id = '{9, 0, 0, 0};
      vecs[2].cut = 16383; vecs[2].e_chi = 16383; vecs[2].e_id = 9; vecs[2].e_n = 1; vecs[2].e_pass = 1;

      bus.CHI = '0; bus.CHI_VALID = 1'b0; bus.FIT_ID = '0; bus.LAST = 1'b0;
      bus.CHI_CUT = '0; bus.OUT_READY = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", bus.OUT_VALID, 0);
      check("reset_best_chi", bus.BEST_CHI, 0);
      check("reset_best_id", bus.BEST_ID, 0);
      check("reset_nfits", bus.NFITS, 0);
      check("reset_pass", bus.PASS, 0);
      check("reset_timed_out", bus.TIMED_OUT, 0);
      check("reset_in_ready", bus.IN_READY, 1);
      rst = 1'b0;

      for (int v = 0; v < 3; v++) begin
         bus.CHI_CUT   = PB'(vecs[v].cut);
         bus.OUT_READY = 1'b1;
         for (int k = 0; k < vecs[v].n; k++)
            send_fit(vecs[v].chi[k], vecs[v].id[k], k == vecs[v].n - 1);
         check($sformatf("vec%0d_out_valid", v), bus.OUT_VALID, 1);
         check($sformatf("vec%0d_best_chi", v), bus.BEST_CHI, vecs[v].e_chi);
         check($sformatf("vec%0d_best_id", v), bus.BEST_ID, vecs[v].e_id);
         check($sformatf("vec%0d_nfits", v), bus.NFITS, vecs[v].e_n);
         check($sformatf("vec%0d_pass", v), bus.PASS, vecs[v].e_pass);
         check($sformatf("vec%0d_timed_out", v), bus.TIMED_OUT, 0);
         idle_cycle();
         check($sformatf("vec%0d_valid_cleared", v), bus.OUT_VALID, 0);
      end

      // Backpressure: result held, next fit stalls upstream, then enters with no loss.
      bus.OUT_READY = 1'b0;
      send_fit(7, 5, 1'b1);
      check("bp_out_valid", bus.OUT_VALID, 1);
      check("bp_in_ready_low", bus.IN_READY, 0);
      bus.CHI = PB'(33); bus.FIT_ID = IB'(6); bus.LAST = 1'b1; bus.CHI_VALID = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check("bp_hold_in_ready", bus.IN_READY, 0);
         check("bp_hold_best_chi", bus.BEST_CHI, 7);
         check("bp_hold_best_id", bus.BEST_ID, 5);
      end
      bus.OUT_READY = 1'b1;
      #1;
      check("bp_release_in_ready", bus.IN_READY, 1);
      @(posedge clk);
      #1;
      bus.CHI_VALID = 1'b0; bus.LAST = 1'b0;
      check("bp_next_out_valid", bus.OUT_VALID, 1);
      check("bp_next_best_chi", bus.BEST_CHI, 33);
      check("bp_next_best_id", bus.BEST_ID, 6);
      check("bp_next_nfits", bus.NFITS, 1);

      // Back-to-back single-fit roads overwrite the register without a bubble.
      send_fit(10, 1, 1'b1);
      check("b2b_first_valid", bus.OUT_VALID, 1);
      check("b2b_first_chi", bus.BEST_CHI, 10);
      check("b2b_first_id", bus.BEST_ID, 1);
      send_fit(20, 2, 1'b1);
      check("b2b_second_valid", bus.OUT_VALID, 1);
      check("b2b_second_chi", bus.BEST_CHI, 20);
      check("b2b_second_id", bus.BEST_ID, 2);

      // Saturating fit counter over a 300-fit road.
      road_chi.delete(); road_id.delete();
      cut = $urandom_range(0, CHI_MAX);
      bus.CHI_CUT = PB'(cut);
      for (int i = 0; i < 300; i++) begin
         v_chi = $urandom_range(0, CHI_MAX);
         road_chi.push_back(v_chi);
         road_id.push_back(i % 256);
         send_fit(v_chi, i % 256, i == 299);
      end
      r = model(cut);
      check("sat_nfits", bus.NFITS, CNT_MAX);
      check("sat_best_chi", bus.BEST_CHI, r.chi);
      check("sat_best_id", bus.BEST_ID, r.id);
      check("sat_pass", bus.PASS, r.pass);

      // Reset mid-road discards the partial road.
      idle_cycle();
      send_fit(5, 1, 1'b0);
      send_fit(6, 2, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_out_valid", bus.OUT_VALID, 0);
      check("midrst_best_chi", bus.BEST_CHI, 0);
      check("midrst_nfits", bus.NFITS, 0);
      check("midrst_in_ready", bus.IN_READY, 1);
      rst = 1'b0;
      bus.CHI_CUT = PB'(150);
      send_fit(100, 3, 1'b0);
      send_fit(200, 4, 1'b1);
      check("postrst_best_chi", bus.BEST_CHI, 100);
      check("postrst_best_id", bus.BEST_ID, 3);
      check("postrst_nfits", bus.NFITS, 2);
      check("postrst_pass", bus.PASS, 1);

      // Randomized roads against the scoreboard, with random gaps and backpressure.
      bus.OUT_READY = 1'b1;
      idle_cycle();
      mon_en = 1'b1;
      rand_ready = 1'b1;
      zero_run = 0;
      for (int rd = 0; rd < 150; rd++) begin
         road_chi.delete(); road_id.delete();
         len = $urandom_range(1, 6);
         cut = $urandom_range(0, CHI_MAX);
         bus.CHI_CUT = PB'(cut);
         for (int k = 0; k < len; k++) begin
            case ($urandom_range(0, 7))
               0:       v_chi = CHI_MAX;
               1, 2:    v_chi = $urandom_range(0, CHI_MAX);
               default: v_chi = $urandom_range(0, 40);
            endcase
            road_chi.push_back(v_chi);
            road_id.push_back($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) idle_cycle();
            send_fit(v_chi, road_id[k], k == len - 1);
         end
         exp_q.push_back(model(cut));
      end
      rand_ready = 1'b0;
      bus.OUT_READY = 1'b1;
      repeat (3) idle_cycle();
      check("scoreboard_drain", exp_q.size(), 0);
      mon_en = 1'b0;

`ifdef CHI_BEST_TIMEOUT_EN
      send_fit(50, 3, 1'b0);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (bus.OUT_VALID) found = 1'b1;
         else idle_cycle();
      end
      check("wd_result_seen", found, 1);
      check("wd_best_chi", bus.BEST_CHI, 50);
      check("wd_best_id", bus.BEST_ID, 3);
      check("wd_nfits", bus.NFITS, 1);
      check("wd_timed_out", bus.TIMED_OUT, 1);
      idle_cycle();
      check("wd_valid_cleared", bus.OUT_VALID, 0);
`else
      send_fit(50, 3, 1'b0);
      found = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (bus.OUT_VALID) found = 1'b1;
         idle_cycle();
      end
      check("nowd_no_forced_close", found, 0);
      send_fit(60, 4, 1'b1);
      check("nowd_best_chi", bus.BEST_CHI, 50);
      check("nowd_nfits", bus.NFITS, 2);
      check("nowd_timed_out", bus.TIMED_OUT, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
